// File: rtl/rf_sched_pkg.sv
// Shared definitions for the register-file write-back scheduler.
// Register-file geometry, default datapath width and the write-back beat type.
package rf_sched_pkg;

  localparam int REG_ADDR_W   = 5;
  localparam int NUM_REGS     = 32;
  localparam int DEFAULT_XLEN = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0]   rd;
    logic [DEFAULT_XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at ptr and wraps.
// Produces a one-hot grant and the pointer to use after that grant.
module rr_arbiter #(
  parameter int W  = 2,
  parameter int PW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [W-1:0]  gnt,
  output logic [PW-1:0] ptr_next,
  output logic          any
);

  int idx;

  always_comb begin
    gnt      = '0;
    ptr_next = ptr;
    any      = 1'b0;
    idx      = 0;
    for (int i = 0; i < W; i++) begin
      idx = (int'(ptr) + i) % W;
      if (!any && req[idx]) begin
        gnt[idx] = 1'b1;
        any      = 1'b1;
        ptr_next = PW'((idx + 1) % W);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Shares the register-file write port among N_REQ requesters and tracks
// destination registers with results still outstanding for hazard checks.
module regfile_wb_scheduler
  import rf_sched_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int XLEN  = DEFAULT_XLEN
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [REG_ADDR_W*N_REQ-1:0] req_rd,
  input  logic [XLEN*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]            req_ready,
  input  logic                        iss_valid,
  input  logic [REG_ADDR_W-1:0]       iss_rd,
  input  logic [REG_ADDR_W-1:0]       chk_a1,
  input  logic [REG_ADDR_W-1:0]       chk_a2,
  output logic                        chk_busy1,
  output logic                        chk_busy2,
  output logic                        rf_we,
  output logic [REG_ADDR_W-1:0]       rf_a3,
  output logic [XLEN-1:0]             rf_wd,
  output logic [NUM_REGS-1:0]         busy_vec,
  output logic                        err
);

  localparam int NA   = N_REQ - 1;
  localparam int APW  = (NA > 1) ? $clog2(NA) : 1;
  localparam int PTRW = $clog2(N_REQ);

  // rr_ptr holds requester numbers 1..N_REQ-1; the arbiter works 0-based.
  logic [PTRW-1:0]       rr_ptr;
  logic [PTRW-1:0]       rr_ptr_m1;
  logic [PTRW-1:0]       rr_ptr_nxt;
  logic [APW-1:0]        arb_ptr;
  logic [APW-1:0]        arb_next;
  logic [NA-1:0]         arb_gnt;
  logic                  arb_any;
  logic                  accept;
  logic [REG_ADDR_W-1:0] sel_rd;
  logic [XLEN-1:0]       sel_wd;
  logic [NUM_REGS-1:0]   busy_nxt;

  assign rr_ptr_m1  = rr_ptr - PTRW'(1);
  assign arb_ptr    = APW'(rr_ptr_m1);
  assign rr_ptr_nxt = PTRW'(arb_next) + PTRW'(1);

  rr_arbiter #(.W(NA), .PW(APW)) u_rr_arbiter (
    .req      (req_valid[N_REQ-1:1]),
    .ptr      (arb_ptr),
    .gnt      (arb_gnt),
    .ptr_next (arb_next),
    .any      (arb_any)
  );

  always_comb begin
    req_ready = '0;
    if (rst_n) begin
      if (req_valid[0]) req_ready[0] = 1'b1;
      else              req_ready    = {arb_gnt, 1'b0};
    end
  end

  assign accept = |req_ready;

  always_comb begin
    sel_rd = '0;
    sel_wd = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (req_ready[k]) begin
        sel_rd = req_rd[REG_ADDR_W*k +: REG_ADDR_W];
        sel_wd = req_data[XLEN*k +: XLEN];
      end
    end
  end

  // Issue is applied after the clear so a same-cycle set wins.
  always_comb begin
    busy_nxt = busy_vec;
    if (accept && sel_rd != '0) busy_nxt[sel_rd] = 1'b0;
    if (iss_valid && iss_rd != '0) busy_nxt[iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= PTRW'(1);
      rf_we    <= 1'b0;
      rf_a3    <= '0;
      rf_wd    <= '0;
      busy_vec <= '0;
      err      <= 1'b0;
    end else begin
      if (!req_valid[0] && arb_any) rr_ptr <= rr_ptr_nxt;
      rf_we <= accept && (sel_rd != '0);
      if (accept) begin
        rf_a3 <= sel_rd;
        rf_wd <= sel_wd;
      end
      busy_vec <= busy_nxt;
      if (iss_valid && iss_rd != '0 && busy_vec[iss_rd]) err <= 1'b1;
    end
  end

  // No bypass: a register stays hazardous until its write has landed.
  assign chk_busy1 = busy_vec[chk_a1] | (rf_we && rf_a3 == chk_a1 && chk_a1 != '0);
  assign chk_busy2 = busy_vec[chk_a2] | (rf_we && rf_a3 == chk_a2 && chk_a2 != '0);

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic
// compared against a behavioural model of arbitration and scoreboard.
module tb_regfile_wb_scheduler;
  import rf_sched_pkg::*;

  localparam int N = 3;
  localparam int X = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [5*N-1:0]  req_rd;
  logic [X*N-1:0]  req_data;
  logic [N-1:0]    req_ready;
  logic            iss_valid;
  logic [4:0]      iss_rd;
  logic [4:0]      chk_a1, chk_a2;
  logic            chk_busy1, chk_busy2;
  logic            rf_we;
  logic [4:0]      rf_a3;
  logic [X-1:0]    rf_wd;
  logic [31:0]     busy_vec;
  logic            err;

  regfile_wb_scheduler #(.N_REQ(N), .XLEN(X)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data), .req_ready(req_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .chk_a1(chk_a1), .chk_a2(chk_a2), .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd), .busy_vec(busy_vec), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model state
  bit          m_busy [32];
  int          m_rr;
  bit          m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_wd;
  bit          m_err;
  int          last_g;
  logic        obs_busy1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_busy_vec();
    logic [31:0] v;
    for (int r = 0; r < 32; r++) v[r] = m_busy[r];
    return v;
  endfunction

  function automatic bit model_hazard(input logic [4:0] a);
    return m_busy[a] || (m_we && m_a3 == a && a != 0);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_busy[r] = 0;
    m_rr = 1; m_we = 0; m_a3 = '0; m_wd = '0; m_err = 0; last_g = -1;
  endtask

  task automatic set_req(input int k, input bit v, input logic [4:0] rd, input logic [31:0] d);
    req_valid[k]      = v;
    req_rd[5*k +: 5]  = rd;
    req_data[X*k +: X] = d;
  endtask

  // Inputs must already be applied; checks combinational outputs, clocks once, checks state.
  task automatic step();
    int g;
    logic [N-1:0] eg;
    logic [4:0]   ard;
    logic [31:0]  awd;
    #1;
    g = -1;
    if (req_valid[0]) g = 0;
    else begin
      for (int i = 0; i < N - 1; i++) begin
        int k;
        k = 1 + ((m_rr - 1 + i) % (N - 1));
        if (g < 0 && req_valid[k]) g = k;
      end
    end
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    check("req_ready", req_ready, eg);
    check("chk_busy1", chk_busy1, model_hazard(chk_a1));
    check("chk_busy2", chk_busy2, model_hazard(chk_a2));
    obs_busy1 = chk_busy1;
    @(posedge clk);
    ard = '0; awd = '0;
    if (g >= 0) begin
      ard = req_rd[5*g +: 5];
      awd = req_data[X*g +: X];
      if (g >= 1) m_rr = (g + 1 > N - 1) ? 1 : g + 1;
    end
    if (iss_valid && iss_rd != 0 && m_busy[iss_rd]) m_err = 1;
    if (g >= 0 && ard != 0) m_busy[ard] = 0;
    if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1;
    m_we = (g >= 0) && (ard != 0);
    if (g >= 0) begin m_a3 = ard; m_wd = awd; end
    last_g = g;
    #1;
    check("rf_we", rf_we, m_we);
    check("rf_a3", rf_a3, m_a3);
    check("rf_wd", rf_wd, m_wd);
    check("busy_vec", busy_vec, model_busy_vec());
    check("err", err, m_err);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"}, rf_we, 1'b0);
    check({tag, "_a3"}, rf_a3, 5'd0);
    check({tag, "_wd"}, rf_wd, 32'd0);
    check({tag, "_busy"}, busy_vec, 32'd0);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_ready"}, req_ready, '0);
  endtask

  logic [31:0] busy_snap;
  wb_req_t     beat;

  initial begin
    rst_n = 1'b0; req_valid = '0; req_rd = '0; req_data = '0;
    iss_valid = 1'b0; iss_rd = '0; chk_a1 = '0; chk_a2 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    req_valid = 3'b111;
    #1;
    check("rst_ready_forced", req_ready, 3'b000);
    req_valid = '0;
    rst_n = 1'b1;
    #1;
    check_reset_outputs("post_rst");
    step();

    // requesters 1 and 2 alternate starting with 1
    set_req(1, 1, 5'd1, 32'h1111_0001);
    set_req(2, 1, 5'd2, 32'h2222_0002);
    step(); check("alt0", last_g, 1);
    step(); check("alt1", last_g, 2);
    step(); check("alt2", last_g, 1);
    step(); check("alt3", last_g, 2);
    set_req(1, 0, 5'd0, 32'd0);

    // requester 0 has priority over requester 2
    set_req(0, 1, 5'd5, 32'hDEAD_BEEF);
    set_req(2, 1, 5'd6, 32'h0000_0606);
    step();
    check("p0_grant", last_g, 0);
    check("p0_we", rf_we, 1'b1);
    check("p0_a3", rf_a3, 5'd5);
    check("p0_wd", rf_wd, 32'hDEAD_BEEF);
    set_req(0, 0, 5'd0, 32'd0);
    step();
    check("p2_grant", last_g, 2);
    set_req(2, 0, 5'd0, 32'd0);

    // issue rd=7, write back through requester 1, watch hazard decay
    iss_valid = 1; iss_rd = 5'd7;
    step();
    iss_valid = 0; chk_a1 = 5'd7;
    step();
    check("haz7_set", obs_busy1, 1'b1);
    set_req(1, 1, 5'd7, 32'h0000_0777);
    step();
    check("haz7_clr_bit", busy_vec[7], 1'b0);
    set_req(1, 0, 5'd0, 32'd0);
    step();
    check("haz7_inflight", obs_busy1, 1'b1);
    step();
    check("haz7_gone", obs_busy1, 1'b0);

    // set beats clear on same register; error on reissue
    iss_valid = 1; iss_rd = 5'd9;
    step();
    set_req(1, 1, 5'd9, 32'h0000_0999);
    step();
    check("set_wins", busy_vec[9], 1'b1);
    check("err_set", err, 1'b1);
    set_req(1, 0, 5'd0, 32'd0);
    iss_rd = 5'd0;
    busy_snap = busy_vec;
    step();
    check("iss_rd0", busy_vec, busy_snap);
    iss_valid = 0;

    // write to x0 is dropped
    beat.rd = 5'd0; beat.data = 32'h0000_1234;
    busy_snap = busy_vec;
    set_req(1, 1, beat.rd, beat.data);
    step();
    check("x0_we", rf_we, 1'b0);
    check("x0_busy", busy_vec, busy_snap);
    set_req(1, 0, 5'd0, 32'd0);

    // clean slate for random traffic
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("rst_a");
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int k = 0; k < N; k++) begin
        if (!(req_valid[k] && last_g != k))
          set_req(k, ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 15)), $urandom);
      end
      iss_valid = ($urandom_range(0, 3) == 0);
      iss_rd    = 5'($urandom_range(0, 15));
      chk_a1    = 5'($urandom_range(0, 15));
      chk_a2    = 5'($urandom_range(0, 15));
      if (cyc == 1000) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("rst_mid");
        @(posedge clk); #1;
        check_reset_outputs("rst_hold");
        rst_n = 1'b1;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
